// File: rtl/boot_uart_rx.sv
// boot_uart_rx: memory-mapped UART receiver feeding a byte FIFO (DATA at 0x0, STATUS at 0x4).
// Define BOOT_UART_RX_PARITY_EN to receive one even-parity bit between data and stop.
module boot_uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        wen,
    input  logic        ren,
    output logic [31:0] rdata,
    input  logic        rx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3;
`ifdef BOOT_UART_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd4;
    localparam logic [2:0] AFTER_DATA = PARITY;
`else
    localparam logic [2:0] AFTER_DATA = STOP;
`endif

    logic [1:0] sync;
    logic rxs, rxs_d;
    logic [2:0] state;
    logic [CW-1:0] cnt;
    logic [2:0] bitn;
    logic [7:0] shift;
    logic tick, push_req, frame_set, par_set, par_bad;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW:0] wp, rp, count;
    logic full, empty, pop, do_push, ovr_set, w1c;
    logic overrun, frame_err, parity_err;
    logic [31:0] status;
    logic unused;

    assign unused = ^{addr[31:4], addr[1:0], wdata[31:5], wdata[2], wdata[0]};
    assign rxs = sync[1];
    assign tick = cnt == '0;
    assign push_req = state == STOP && tick && rxs && !par_bad;
    assign frame_set = state == STOP && tick && !rxs;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= 2'b11;
            rxs_d <= 1'b1;
        end else begin
            sync <= {sync[0], rx};
            rxs_d <= rxs;
        end
    end

    // The counter free-runs and reloads a full bit period on every expiry; states only override it on entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            bitn <= '0;
            shift <= '0;
        end else begin
            cnt <= tick ? CW'(CLKS_PER_BIT - 1) : cnt - 1'b1;
            case (state)
                IDLE: if (rxs_d && !rxs) begin
                    state <= START;
                    cnt <= CW'(CLKS_PER_BIT / 2 - 1);
                end
                START: if (tick) begin
                    state <= rxs ? IDLE : DATA;
                    bitn <= '0;
                end
                DATA: if (tick) begin
                    shift <= {rxs, shift[7:1]};
                    bitn <= bitn + 1'b1;
                    if (bitn == 3'd7) state <= AFTER_DATA;
                end
`ifdef BOOT_UART_RX_PARITY_EN
                PARITY: if (tick) state <= STOP;
`endif
                STOP: if (tick) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BOOT_UART_RX_PARITY_EN
    assign par_set = state == PARITY && tick && (rxs != ^shift);
    always_ff @(posedge clk) begin
        if (rst) par_bad <= 1'b0;
        else if (state == PARITY && tick) par_bad <= rxs != ^shift;
    end
`else
    assign par_set = 1'b0;
    assign par_bad = 1'b0;
`endif

    assign count = wp - rp;
    assign full = count == (AW + 1)'(FIFO_DEPTH);
    assign empty = wp == rp;
    assign pop = sel && ren && addr[3:2] == 2'd0 && !empty;
    assign do_push = push_req && (!full || pop);
    assign ovr_set = push_req && full && !pop;
    assign w1c = sel && wen && addr[3:2] == 2'd1;
    assign status = {27'b0, parity_err, frame_err, !empty, overrun, full};

    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= shift;
    end

    // Sticky flags: a set in the same cycle as its W1C clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            overrun <= 1'b0;
            frame_err <= 1'b0;
            parity_err <= 1'b0;
            rdata <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            overrun <= ovr_set | (overrun & ~(w1c & wdata[1]));
            frame_err <= frame_set | (frame_err & ~(w1c & wdata[3]));
            parity_err <= par_set | (parity_err & ~(w1c & wdata[4]));
            if (sel && ren)
                rdata <= addr[3:2] == 2'd0 ? (empty ? 32'd0 : {24'b0, mem[rp[AW-1:0]]}) :
                         addr[3:2] == 2'd1 ? status : 32'd0;
        end
    end
endmodule

// File: tb/tb_boot_uart_rx.sv
// tb_boot_uart_rx: directed plan checks plus randomized frames/bus ops against a queue-based model.
module tb_boot_uart_rx;
    localparam int CPB = 4;
    localparam int DEPTH = 8;
`ifdef BOOT_UART_RX_PARITY_EN
    localparam int NB = 11;
    localparam bit PAR = 1'b1;
`else
    localparam int NB = 10;
    localparam bit PAR = 1'b0;
`endif
    // Stop-bit sample edge: 2 sync + 1 edge-detect cycles, half a bit, then NB-1 whole bits.
    localparam int POP_AT = 2 + CPB / 2 + (NB - 1) * CPB;

    logic clk = 1'b0, rst = 1'b1, sel = 1'b0, wen = 1'b0, ren = 1'b0, rx = 1'b1;
    logic [31:0] addr = '0, wdata = '0, rdata;
    int n_checks = 0, n_errors = 0;
    logic [7:0] q[$];
    logic m_ovr = 1'b0, m_fe = 1'b0, m_pe = 1'b0;

    boot_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .sel(sel), .addr(addr), .wdata(wdata),
        .wen(wen), .ren(ren), .rdata(rdata), .rx(rx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(posedge clk); #1 sel = 1'b1; ren = 1'b1; addr = a;
        @(posedge clk); #1 sel = 1'b0; ren = 1'b0; d = rdata;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] w);
        @(posedge clk); #1 sel = 1'b1; wen = 1'b1; addr = a; wdata = w;
        @(posedge clk); #1 sel = 1'b0; wen = 1'b0;
        if (w[1]) m_ovr = 1'b0;
        if (w[3]) m_fe = 1'b0;
        if (w[4]) m_pe = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] v;
        v = '0;
        if (a[3:2] == 2'd0 && q.size() > 0) v = {24'b0, q.pop_front()};
        else if (a[3:2] == 2'd1) v = {27'b0, m_pe, m_fe, q.size() != 0, m_ovr, q.size() == DEPTH};
        return v;
    endfunction

    // Sends one frame plus two idle bits; optionally pops DATA in cycle pop_at of the frame.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbad,
                              input int pop_at, output logic [31:0] popped);
        logic [15:0] bits;
        logic pb;
        pb = PAR && pbad;
`ifdef BOOT_UART_RX_PARITY_EN
        bits = {4'hF, stop, ^d ^ pb, d, 1'b0};
`else
        bits = {5'h1F, stop, d, 1'b0};
`endif
        popped = '0;
        for (int c = 0; c < (NB + 2) * CPB; c++) begin
            @(posedge clk); #1;
            rx = bits[c / CPB];
            sel = c == pop_at;
            ren = c == pop_at;
            addr = '0;
            if (c == pop_at + 1) popped = rdata;
        end
        if (pop_at >= 0 && q.size() > 0) void'(q.pop_front());
        if (!stop) m_fe = 1'b1;
        if (pb) m_pe = 1'b1;
        if (stop && !pb) begin
            if (q.size() == DEPTH) m_ovr = 1'b1;
            else q.push_back(d);
        end
    endtask

    initial begin
        logic [31:0] d, w, a;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_rdata", rdata, 32'h0);
        rd("reset_status", 32'h4, 32'h0);
        rd("empty_data", 32'h0, 32'h0);
        rd("empty_no_pop", 32'h4, 32'h0);

        send_frame(8'hA5, 1'b1, 1'b0, -1, d);
        rd("a5_status", 32'h4, 32'h4);
        rd("a5_data", 32'h0, 32'hA5);
        rd("a5_drained", 32'h4, 32'h0);

        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 1'b0, -1, d);
        rd("ovr_status", 32'h4, 32'h7);
        for (int i = 1; i <= 8; i++) rd("ovr_data", 32'h0, 32'(i));
        rd("ovr_sticky", 32'h4, 32'h2);
        bus_write(32'h4, 32'h2);
        rd("ovr_cleared", 32'h4, 32'h0);

        send_frame(8'h3C, 1'b0, 1'b0, -1, d);
        rd("fe_status", 32'h4, 32'h8);
        rd("fe_no_data", 32'h0, 32'h0);
        bus_write(32'h4, 32'h8);
        rd("fe_cleared", 32'h4, 32'h0);
        @(posedge clk); #1 rx = 1'b0;
        @(posedge clk); #1 rx = 1'b1;
        repeat (4 * CPB) @(posedge clk);
        rd("glitch_status", 32'h4, 32'h0);

        for (int i = 0; i < 8; i++) send_frame(8'(8'h10 + i), 1'b1, 1'b0, -1, d);
        rd("full_status", 32'h4, 32'h5);
        send_frame(8'h18, 1'b1, 1'b0, POP_AT, d);
        check("pop_on_push_data", d, 32'h10);
        rd("pop_on_push_status", 32'h4, 32'h5);
        for (int i = 0; i < 8; i++) rd("pop_on_push_order", 32'h0, 32'(8'h11 + i));
        rd("pop_on_push_drained", 32'h4, 32'h0);

`ifdef BOOT_UART_RX_PARITY_EN
        send_frame(8'h03, 1'b1, 1'b1, -1, d);
        rd("par_status", 32'h4, 32'h10);
        rd("par_no_data", 32'h0, 32'h0);
        bus_write(32'h4, 32'h10);
        rd("par_cleared", 32'h4, 32'h0);
        send_frame(8'h03, 1'b1, 1'b0, -1, d);
        rd("par_ok_status", 32'h4, 32'h4);
        rd("par_ok_data", 32'h0, 32'h3);
`endif

        @(posedge clk); #1 rx = 1'b0;
        repeat (5 * CPB) @(posedge clk);
        #1 rst = 1'b1; rx = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("midframe_rst_rdata", rdata, 32'h0);
        repeat (NB * CPB) @(posedge clk);
        rd("midframe_rst_status", 32'h4, 32'h0);
        send_frame(8'h5A, 1'b1, 1'b0, -1, d);
        rd("post_rst_status", 32'h4, 32'h4);
        rd("post_rst_data", 32'h0, 32'h5A);

        q.delete();
        m_ovr = 1'b0; m_fe = 1'b0; m_pe = 1'b0;
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 5))
                0, 1: send_frame(8'($urandom), $urandom_range(0, 7) != 0,
                                 $urandom_range(0, 7) == 0, -1, d);
                2: rd("rnd_data", 32'h0, model_read(32'h0));
                3: rd("rnd_status", 32'h4, model_read(32'h4));
                4: begin
                    w = $urandom;
                    bus_write(32'h4, w);
                end
                default: begin
                    a = {$urandom} & 32'hFFFF_FFF3 | (32'($urandom_range(2, 3)) << 2);
                    rd("rnd_unmapped", a, model_read(a));
                end
            endcase
        end
        while (q.size() > 0) rd("rnd_drain", 32'h0, model_read(32'h0));
        rd("rnd_final_status", 32'h4, model_read(32'h4));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/boot_uart_rx.md
# boot_uart_rx

Memory-mapped UART receiver with a byte FIFO. It is the device side of the boot-time polling loop: the bootloader reads STATUS at offset 0x4 until bit 2 (RX_VALID) is set, then reads DATA at offset 0x0 to pop one byte. It sits on the same single-cycle registered-read bus as the boot RAM, behind an upstream address decode that supplies `sel`.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per UART bit, ≥4; 434 gives 115200 baud at 50 MHz.
- `FIFO_DEPTH`, 8, RX FIFO entries, power of two, ≥2.
- `clk` in 1: the only clock; all logic on posedge.
- `rst` in 1: reset, synchronous, active-high.
- `sel` in 1: the block is addressed this cycle.
- `addr` in 32: byte address; only `addr[3:2]` is decoded.
- `wdata` in 32: write data.
- `wen` in 1: write strobe, qualified by `sel`.
- `ren` in 1: read strobe, qualified by `sel`; a DATA read with `ren` pops the FIFO.
- `rdata` out 32: registered read data.
- `rx` in 1: asynchronous serial input, idles high.

## Operation
- Registers, selected by `addr[3:2]`:
  - 0 DATA (RO): `{24'b0, head byte}`; 0 when the FIFO is empty.
  - 1 STATUS:
    - bit0 FULL (RO).
    - bit1 OVERRUN (W1C).
    - bit2 RX_VALID = FIFO not empty (RO).
    - bit3 FRAME_ERR (W1C).
    - bit4 PARITY_ERR (W1C; reads 0 unless parity is compiled in).
    - Other bits read 0.
  - 2, 3: read 0; writes ignored.
- Pop: `sel && ren && addr[3:2]==0 && !empty`. Reading DATA while empty returns 0 and does not pop.
- W1C: `sel && wen && addr[3:2]==1` clears each sticky bit whose `wdata` bit is 1. If a set and a clear hit the same cycle, the set wins.
- `rx` passes through a 2-flop synchronizer; the FSM sees the synchronized signal `rxs`.
- FSM states: IDLE, START, DATA, (PARITY), STOP.
  - IDLE: a falling edge on `rxs` loads the bit counter with CLKS_PER_BIT/2 − 1 and enters START.
  - START: at counter expiry, `rxs`==0 enters DATA (counter reloads to CLKS_PER_BIT−1). `rxs`==1 is a glitch: return to IDLE, no flag set.
  - DATA: samples 8 bits LSB-first, one per counter expiry, then enters PARITY or STOP.
  - STOP: samples at counter expiry, then returns to IDLE the same cycle.
    - Sample 1: byte is pushed.
    - Sample 0: FRAME_ERR is set and the byte is discarded. IDLE requires a high-then-low transition, so a held break does not retrigger.
- Push when FULL with no pop in the same cycle: byte dropped, OVERRUN set, FIFO contents unchanged.
- Push and pop in the same cycle: both take effect and the count is unchanged. This includes the full case, where OVERRUN is not set.

## Timing
- Reset values:
  - `rdata` = 0.
  - FSM in IDLE.
  - FIFO empty.
  - All sticky flags 0.
  - Synchronizer flops = 1.
- `rst` asserted mid-frame aborts the frame: no push, no flag. After reset the FSM waits for a fresh falling edge.
- Read latency is 1 cycle: `rdata` updates on the clock edge after the `ren` cycle, and holds its value when there is no read.
- A popped byte is removed at that same edge. A STATUS read issued the next cycle reflects the pop.
- Input latency is 2 cycles (synchronizer) from an `rx` edge to `rxs`.
- The push occurs on the cycle of the stop-bit sample, about 9.5 × CLKS_PER_BIT + 2 cycles after the start edge on `rx` (10.5 × with parity). RX_VALID is readable by a STATUS read issued on the following cycle.
- FIFO pointers wrap modulo FIFO_DEPTH. An extra pointer bit distinguishes full from empty.

## Configuration
- `BOOT_UART_RX_PARITY_EN` defined:
  - Adds a PARITY state between DATA and STOP that samples one even-parity bit.
  - On mismatch, PARITY_ERR is set and the byte is discarded, even if the stop bit is good.
  - Frame length is 11 bits.
- Not defined: no PARITY state, 10-bit frames, STATUS bit4 reads 0.

## Test plan
- Reset, then read STATUS: `rdata`=0. Read DATA: `rdata`=0, no pop.
- CLKS_PER_BIT=4: send 0xA5 with a good stop bit, then poll STATUS. Expect 0x4; DATA returns 0x000000A5; STATUS then reads 0x0.
- Send 9 bytes 0x01..0x09 with FIFO_DEPTH=8 and no reads. Expect STATUS=0x7; the 8 DATA reads return 0x01..0x08; OVERRUN stays set until W1C `wdata`=0x2, then STATUS=0x0.
- Send 0x3C with stop bit 0. Expect STATUS=0x8 and no data. W1C 0x8 gives STATUS=0x0. Then a 1-cycle low glitch on `rx` causes no push and no flag.
- FIFO full, with a DATA pop on the exact cycle of a new byte's push. Expect no OVERRUN, count stays 8, and the new byte arrives last in order.
- Parity build: send 0x03 with parity 1 (bad, even parity expects 0). Expect STATUS=0x10 and empty FIFO. The same byte with parity 0 is received as 0x03.
